// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit bounds and the load sanitiser used by the
// multi-digit BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Clamp an arbitrary nibble into the legal BCD range (values above 9 become 9).
  function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: sync reset, parallel load with sanitising, and a
// single-step up/down count gated by en. Bound flags feed the carry lookahead.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       en,
  input  logic       up_down,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t q_r;
  bcd_digit_t q_step;

  always_comb begin
    q_step = q_r;
    if (up_down) begin
      q_step = (q_r >= BCD_MAX) ? BCD_MIN : q_r + 4'd1;
    end else begin
      q_step = (q_r == BCD_MIN) ? BCD_MAX : q_r - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= BCD_MIN;
    end else if (load) begin
      q_r <= bcd_sanitise(load_digit);
    end else if (en) begin
      q_r <= q_step;
    end
  end

  assign q      = q_r;
  assign at_max = (q_r == BCD_MAX);
  assign at_min = (q_r == BCD_MIN);

endmodule

// File: rtl/bcd_count_multi.sv
// Multi-digit BCD up/down counter with lookahead carry/borrow, parallel load,
// optional saturation at the bounds, a cascade terminal count and a wrap pulse.
module bcd_count_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cen,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tc,
  output logic                  wrapped
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS:0]   pre_max;
  logic [DIGITS:0]   pre_min;
  logic              count_req;
  logic              bound_hit;
  logic              count_eff;
  logic              wrapped_r;

  assign count_req = ~cen & ~load;
  // A count attempt at the bound in the current direction is both the
  // cascade terminal count and the wrap/saturation event.
  assign bound_hit = count_req & (up_down ? pre_max[DIGITS] : pre_min[DIGITS]);
  assign count_eff = (SATURATE != 0) ? (count_req & ~bound_hit) : count_req;

  // Prefix ANDs of lower-digit bound flags: every digit's enable is ready in
  // the same cycle, so the whole word updates on one edge.
  always_comb begin
    pre_max    = '0;
    pre_min    = '0;
    dig_en     = '0;
    pre_max[0] = 1'b1;
    pre_min[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      pre_max[i+1] = pre_max[i] & at_max[i];
      pre_min[i+1] = pre_min[i] & at_min[i];
      dig_en[i]    = count_eff & (up_down ? pre_max[i] : pre_min[i]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_val[4*g +: 4]),
      .en         (dig_en[g]),
      .up_down    (up_down),
      .q          (Q[4*g +: 4]),
      .at_max     (at_max[g]),
      .at_min     (at_min[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrapped_r <= 1'b0;
    end else begin
      wrapped_r <= bound_hit;
    end
  end

  assign tc      = bound_hit;
  assign wrapped = wrapped_r;

endmodule

// File: tb/tb_bcd_count_multi.sv
// Directed bench for bcd_count_multi: a 3-digit wrapping counter and a
// 2-digit saturating counter, checked against hand-computed values.
module tb_bcd_count_multi;

  logic        clk;
  logic        a_reset, a_cen, a_up_down, a_load;
  logic [11:0] a_load_val, a_q;
  logic        a_tc, a_wrapped;
  logic        b_reset, b_cen, b_up_down, b_load;
  logic [7:0]  b_load_val, b_q;
  logic        b_tc, b_wrapped;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];

  bcd_count_multi #(.DIGITS(3), .SATURATE(0)) dut_a (
    .clk(clk), .reset(a_reset), .cen(a_cen), .up_down(a_up_down),
    .load(a_load), .load_val(a_load_val), .Q(a_q), .tc(a_tc), .wrapped(a_wrapped)
  );

  bcd_count_multi #(.DIGITS(2), .SATURATE(1)) dut_b (
    .clk(clk), .reset(b_reset), .cen(b_cen), .up_down(b_up_down),
    .load(b_load), .load_val(b_load_val), .Q(b_q), .tc(b_tc), .wrapped(b_wrapped)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    exp_q.push_back(exp);
    assert (obs === exp_q.pop_front()) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic a_drive(input logic rst, input logic ld, input logic [11:0] val,
                         input logic c, input logic ud);
    a_reset = rst; a_load = ld; a_load_val = val; a_cen = c; a_up_down = ud;
  endtask

  task automatic b_drive(input logic rst, input logic ld, input logic [7:0] val,
                         input logic c, input logic ud);
    b_reset = rst; b_load = ld; b_load_val = val; b_cen = c; b_up_down = ud;
  endtask

  initial begin
    a_drive(1, 0, 12'h000, 1, 1);
    b_drive(1, 0, 8'h00, 1, 1);
    step();
    check("a_reset_q", 32'(a_q), 32'h000);
    check("a_reset_wrapped", 32'(a_wrapped), 0);
    check("a_reset_tc", 32'(a_tc), 0);

    // load with sanitising
    a_drive(0, 1, 12'h2F7, 1, 1); step();
    check("a_load_sanitise", 32'(a_q), 32'h297);
    a_drive(0, 1, 12'hFAB, 1, 1); step();
    check("a_load_all_sanitise", 32'(a_q), 32'h999);

    // up carry chain
    a_drive(0, 1, 12'h199, 1, 1); step();
    a_drive(0, 0, 12'h000, 0, 1);
    check("a_tc_not_top", 32'(a_tc), 0);
    step();
    check("a_up_carry_q", 32'(a_q), 32'h200);
    check("a_up_carry_wrapped", 32'(a_wrapped), 0);

    // down borrow and wrap
    a_drive(0, 1, 12'h001, 1, 1); step();
    a_drive(0, 0, 12'h000, 0, 0); step();
    check("a_down_q0", 32'(a_q), 32'h000);
    check("a_down_wrapped0", 32'(a_wrapped), 0);
    check("a_tc_at_zero_down", 32'(a_tc), 1);
    step();
    check("a_down_wrap_q", 32'(a_q), 32'h999);
    check("a_down_wrap_pulse", 32'(a_wrapped), 1);
    check("a_tc_999_down", 32'(a_tc), 0);
    a_cen = 1; step();
    check("a_hold_q", 32'(a_q), 32'h999);
    check("a_pulse_one_cycle", 32'(a_wrapped), 0);

    // up wrap, then tc masked by load
    a_cen = 0; a_up_down = 1; #1;
    check("a_tc_top_up", 32'(a_tc), 1);
    a_load = 1; a_load_val = 12'h999; #1;
    check("a_tc_masked_load", 32'(a_tc), 0);
    a_load = 0; #1;
    step();
    check("a_up_wrap_q", 32'(a_q), 32'h000);
    check("a_up_wrap_pulse", 32'(a_wrapped), 1);

    // priority: load over count, reset over load
    a_drive(0, 1, 12'h045, 1, 1); step();
    a_drive(0, 1, 12'h123, 0, 1); step();
    check("a_load_over_count", 32'(a_q), 32'h123);
    check("a_load_no_wrapped", 32'(a_wrapped), 0);
    a_drive(1, 1, 12'h777, 0, 1); step();
    check("a_reset_over_load", 32'(a_q), 32'h000);

    // direction flip and hold
    a_drive(0, 1, 12'h009, 1, 1); step();
    a_drive(0, 0, 12'h000, 0, 1); step();
    check("a_flip_up", 32'(a_q), 32'h010);
    a_up_down = 0; step();
    check("a_flip_down", 32'(a_q), 32'h009);
    a_cen = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("a_hold5_q", 32'(a_q), 32'h009);
      check("a_hold5_tc", 32'(a_tc), 0);
    end

    // reset clears a pending wrap pulse
    a_drive(0, 1, 12'h000, 1, 0); step();
    a_drive(0, 0, 12'h000, 0, 0); step();
    check("a_pre_reset_pulse", 32'(a_wrapped), 1);
    a_reset = 1; step();
    check("a_reset_clears_q", 32'(a_q), 32'h000);
    check("a_reset_clears_wrapped", 32'(a_wrapped), 0);
    a_drive(0, 0, 12'h000, 1, 1);

    // saturating 2-digit counter
    check("b_reset_q", 32'(b_q), 32'h00);
    b_drive(0, 1, 8'h98, 1, 1); step();
    b_drive(0, 0, 8'h00, 0, 1); step();
    check("b_sat_q1", 32'(b_q), 32'h99);
    check("b_sat_w1", 32'(b_wrapped), 0);
    check("b_sat_tc", 32'(b_tc), 1);
    step();
    check("b_sat_q2", 32'(b_q), 32'h99);
    check("b_sat_w2", 32'(b_wrapped), 1);
    step();
    check("b_sat_q3", 32'(b_q), 32'h99);
    check("b_sat_w3", 32'(b_wrapped), 1);
    b_cen = 1; step();
    check("b_sat_w_clear", 32'(b_wrapped), 0);
    b_drive(0, 1, 8'h00, 1, 0); step();
    b_drive(0, 0, 8'h00, 0, 0); step();
    check("b_sat_low_q", 32'(b_q), 32'h00);
    check("b_sat_low_w", 32'(b_wrapped), 1);
    b_up_down = 1; step();
    check("b_up_from_zero", 32'(b_q), 32'h01);
    check("b_up_from_zero_w", 32'(b_wrapped), 0);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
